uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters; all outputs registered.
// Optional launch watchdog enabled by defining UART_ARB_TIMEOUT_EN (err tied low otherwise).
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_winner, last_nxt;
  logic [NREQ-1:0]   grant_nxt;
  logic [NREQ-1:0]   ack_nxt;
  logic              tx_start_nxt;
  logic [7:0]        tx_data_nxt;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  to_cnt, to_cnt_nxt;
  logic              err_r, err_nxt;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  logic [7:0] req_byte [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // Round-robin search starting just after the previous winner, wrapping at NREQ.
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_winner;
    cand     = last_winner;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((int'(last_winner) + off) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last_winner;
    grant_nxt    = grant;
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
`ifdef UART_ARB_TIMEOUT_EN
    err_nxt      = 1'b0;
    to_cnt_nxt   = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt   = ONE << pick_idx;
          tx_data_nxt = req_byte[pick_idx];
          last_nxt    = pick_idx;
          state_nxt   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_nxt = 1'b1;
        state_nxt    = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_nxt   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // A timed-out launch drops the owner without an ack; the pointer already moved past it.
        else if (to_cnt == CNT_W'(TIMEOUT)) begin
          err_nxt   = 1'b1;
          grant_nxt = '0;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + CNT_W'(1);
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          ack_nxt   = grant;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= IDX_W'(NREQ - 1);
      grant       <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      err_r       <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      last_winner <= last_nxt;
      grant       <= grant_nxt;
      ack         <= ack_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
`ifdef UART_ARB_TIMEOUT_EN
      err_r       <= err_nxt;
      to_cnt      <= to_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, scoreboarded per requester.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // What the DUT saw at the last rising edge
  logic [NREQ-1:0] req_s;
  logic            rst_s;
  always @(posedge clk) begin
    req_s <= req;
    rst_s <= rst;
  end

  // Transmitter model: busy rises one cycle after tx_start and stays high 10 cycles
  logic       mute = 1'b0;
  logic       arm = 1'b0;
  int         busy_left = 0;
  logic [7:0] rx_last = 8'h00;
  always @(negedge clk) begin
    if (tx_busy) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) tx_busy = 1'b0;
    end else if (arm) begin
      tx_busy   = 1'b1;
      busy_left = 10;
      arm       = 1'b0;
    end
    if (tx_start && !mute) begin
      arm     = 1'b1;
      rx_last = tx_data;
    end
  end

  // Scoreboard state
  logic [7:0]      exp_q [NREQ][$];
  int              grant_log[$];
  logic [7:0]      data_log[$];
  int              ack_cnt [NREQ] = '{default: 0};
  int              ack_tot = 0, start_cnt = 0, err_cnt = 0;
  int              cyc = 0, owner = -1, m_last = NREQ - 1, gcyc = -100, start_cyc = -100, w;
  logic [NREQ-1:0] grant_prev = '0;
  logic [7:0]      lat_data, exp_b;

  // Monitor: predicts each winner from the sampled requests and the rotating priority
  always @(negedge clk) begin
    cyc++;
    if (rst_s) begin
      owner = -1; m_last = NREQ - 1; grant_prev = '0;
    end else begin
      if ((grant | ack) != '0) begin
        check("grant_onehot", $countones(grant) <= 1, 1);
        check("ack_onehot", $countones(ack) <= 1, 1);
      end
      if (ack != '0) begin
        if (owner < 0) check("ack_no_owner", ack, 0);
        else begin
          check("ack_owner", ack, onehot(owner));
          check("ack_grant_clr", grant, 0);
          check("ack_pending", exp_q[owner].size() > 0, 1);
          if (exp_q[owner].size() > 0) begin
            exp_b = exp_q[owner].pop_front();
            check("ack_rx_byte", rx_last, exp_b);
            check("ack_tx_data", tx_data, exp_b);
          end
          ack_cnt[owner]++; ack_tot++; owner = -1;
        end
      end
      if (err) begin
`ifdef UART_ARB_TIMEOUT_EN
        check("err_owner", owner >= 0, 1);
        check("err_latency", cyc - start_cyc, TO + 1);
        check("err_grant_clr", grant, 0);
        check("err_no_ack", ack, 0);
        err_cnt++; owner = -1;
`else
        check("err_tied_low", err, 0);
`endif
      end
      if (grant != '0 && grant_prev == '0) begin
        w = -1;
        for (int off = 1; off <= NREQ; off++)
          if (w < 0 && req_s[(m_last + off) % NREQ]) w = (m_last + off) % NREQ;
        if (w < 0) check("grant_spurious", grant, 0);
        else begin
          check("grant_rr", grant, onehot(w));
          check("grant_pending", exp_q[w].size(), 1);
          if (exp_q[w].size() > 0) check("grant_tx_data", tx_data, exp_q[w][0]);
          owner = w; m_last = w; gcyc = cyc; lat_data = tx_data;
          grant_log.push_back(w); data_log.push_back(tx_data);
        end
      end else if (owner >= 0 && grant != '0) begin
        check("tx_data_stable", tx_data, lat_data);
      end
      if (tx_start) begin
        check("start_latency", cyc - gcyc, 1);
        start_cyc = cyc; start_cnt++;
      end
      grant_prev = grant;
    end
  end

  // Stimulus: mode 0 drops req on ack, 1 re-requests the same byte, 2 re-requests a random byte
  int   mode [NREQ] = '{default: 0};
  logic rand_on = 1'b0;

  task automatic raise(int i, logic [7:0] b);
    req_data[8*i +: 8] = b;
    req[i] = 1'b1;
    exp_q[i].push_back(b);
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        if (mode[i] == 1) raise(i, req_data[8*i +: 8]);
        else if (mode[i] == 2) raise(i, 8'($urandom));
        else req[i] = 1'b0;
      end
      if (rand_on) begin
        if (grant[i] && $urandom_range(0, 3) == 0) req_data[8*i +: 8] = 8'($urandom);
        if (!req[i] && $urandom_range(0, 5) == 0) raise(i, 8'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rand_on = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      mode[i] = 0;
      exp_q[i].delete();
    end
    for (int k = 0; k < 30 && (tx_busy || arm); k++) tick();
    tick(); tick();
    grant_log.delete(); data_log.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_grants(int n, int budget, string name);
    int k;
    k = 0;
    while (grant_log.size() < n && k < budget) begin tick(); k++; end
    check({name, "_grants_reached"}, grant_log.size() >= n, 1);
  endtask

  task automatic wait_ack(int i, int budget, string name);
    int k, a0;
    k = 0; a0 = ack_cnt[i];
    while (ack_cnt[i] == a0 && k < budget) begin tick(); k++; end
    check({name, "_ack_seen"}, ack_cnt[i] - a0, 1);
  endtask

  int         s0, a0, gbad, gseen, k, pend, g0;
  int         ackd [NREQ];
  int         ord [5] = '{0, 1, 2, 3, 0};
  logic [7:0] dat [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    tick(); tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    tick();

    // Single request from requester 2
    s0 = start_cnt; a0 = ack_cnt[2]; gbad = 0; gseen = 0; k = 0;
    raise(2, 8'h41);
    while (ack_cnt[2] == a0 && k < 100) begin
      tick(); k++;
      if (grant != '0) begin
        gseen++;
        if (grant != 4'b0100) gbad++;
      end
      if (tx_start) check("single_tx_data", tx_data, 8'h41);
    end
    check("single_ack", ack_cnt[2] - a0, 1);
    check("single_starts", start_cnt - s0, 1);
    check("single_rx", rx_last, 8'h41);
    check("single_grant_value", gbad, 0);
    check("single_grant_cycles", gseen, 13);

    // Contention: all four held high
    do_reset();
    for (int i = 0; i < NREQ; i++) begin mode[i] = 1; ackd[i] = ack_cnt[i]; end
    raise(0, 8'h10); raise(1, 8'h21); raise(2, 8'h32); raise(3, 8'h43);
    wait_grants(5, 200, "contention");
    if (grant_log.size() >= 5)
      for (int j = 0; j < 5; j++) begin
        check("contention_order", grant_log[j], ord[j]);
        check("contention_data", data_log[j], dat[j]);
      end
    for (int i = 0; i < NREQ; i++) check("contention_acks", ack_cnt[i] - ackd[i], 1);

    // Fairness: req3 arrives while requester 0 holds the transmitter
    do_reset();
    mode[0] = 1;
    raise(0, 8'h55);
    wait_grants(1, 50, "fair_first");
    raise(3, 8'h66);
    wait_grants(3, 200, "fair");
    if (grant_log.size() >= 3) begin
      check("fair_second", grant_log[1], 3);
      check("fair_third", grant_log[2], 0);
    end

    // Request drop one cycle after tx_start
    do_reset();
    raise(1, 8'h77);
    k = 0;
    while (!tx_start && k < 50) begin tick(); k++; end
    check("drop_start_seen", tx_start, 1);
    tick();
    req[1] = 1'b0;
    wait_ack(1, 50, "drop");
    g0 = grant_log.size();
    repeat (30) tick();
    check("drop_no_regrant", grant_log.size() - g0, 0);
    check("drop_grant_idle", grant, 0);

    // Reset while waiting for the transmitter to finish
    do_reset();
    mode[2] = 1;
    raise(2, 8'h99);
    k = 0;
    while (!(tx_busy && grant != '0) && k < 50) begin tick(); k++; end
    tick(); tick();
    check("midrst_in_transfer", grant, 4'b0100);
    a0 = ack_tot;
    rst = 1'b1; req = '0; mode[2] = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    check("midrst_grant", grant, 0);
    check("midrst_ack", ack, 0);
    check("midrst_err", err, 0);
    check("midrst_tx_start", tx_start, 0);
    check("midrst_tx_data", tx_data, 8'h00);
    repeat (15) tick();
    check("midrst_no_ack", ack_tot - a0, 0);
    grant_log.delete(); data_log.delete();
    raise(1, 8'hA1); raise(3, 8'hA3);
    wait_grants(1, 50, "midrst");
    if (grant_log.size() >= 1) check("midrst_first", grant_log[0], 1);
    wait_ack(3, 100, "midrst_tail");

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never answers the first launch
    do_reset();
    mute = 1'b1;
    a0 = ack_cnt[0]; s0 = err_cnt;
    raise(0, 8'hC0); raise(1, 8'hC1);
    k = 0;
    while (err_cnt == s0 && k < 200) begin tick(); k++; end
    check("timeout_err_count", err_cnt - s0, 1);
    check("timeout_no_ack", ack_cnt[0] - a0, 0);
    mute = 1'b0;
    wait_grants(2, 50, "timeout");
    if (grant_log.size() >= 2) begin
      check("timeout_first", grant_log[0], 0);
      check("timeout_next", grant_log[1], 1);
    end
    wait_ack(1, 100, "timeout_next");
    wait_ack(0, 100, "timeout_retry");
`endif

    // Random traffic with re-requests and data scribbling on the owner
    do_reset();
    for (int i = 0; i < NREQ; i++) mode[i] = 2;
    rand_on = 1'b1;
    repeat (3000) tick();
    rand_on = 1'b0;
    for (int i = 0; i < NREQ; i++) mode[i] = 0;
    k = 0; pend = 1;
    while (pend != 0 && k < 2000) begin
      tick(); k++;
      pend = 0;
      for (int i = 0; i < NREQ; i++) pend += exp_q[i].size();
    end
    check("random_drained", pend, 0);
    check("random_some_traffic", ack_tot > 150, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
